// File: rtl/cordic_sincos.sv
// cordic_sincos: iterative rotation CORDIC, angle to cos/sin; CORDIC_RANGE_CHECK_EN adds |angle|>pi/2 rejection via err
module cordic_sincos #(
    parameter int ITER = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] angle_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] cos_out,
    output logic signed [31:0] sin_out,
    output logic               err
);
    localparam logic [1:0] IDLE = 2'd0, ROTATE = 2'd1, HOLD = 2'd2;
    localparam logic signed [31:0] K = 32'sd652032874;
    localparam logic signed [31:0] AMAX = 32'sd1686629713;
    localparam logic signed [31:0] ATAN [0:30] = '{
        32'sd843314857, 32'sd497837830, 32'sd263043837, 32'sd133525159,
        32'sd67021687,  32'sd33543516,  32'sd16775851,  32'sd8388437,
        32'sd4194283,   32'sd2097149,   32'sd1048576,   32'sd524288,
        32'sd262144,    32'sd131072,    32'sd65536,     32'sd32768,
        32'sd16384,     32'sd8192,      32'sd4096,      32'sd2048,
        32'sd1024,      32'sd512,       32'sd256,       32'sd128,
        32'sd64,        32'sd32,        32'sd16,        32'sd8,
        32'sd4,         32'sd2,         32'sd1
    };
    logic [1:0] state;
    logic [4:0] i;
    logic signed [31:0] x, y, z, x_n, y_n, z_n;
    logic oor;
    assign in_ready = state == IDLE;
    assign out_valid = state == HOLD;
    always_comb begin
        x_n = z[31] ? x + (y >>> i) : x - (y >>> i);
        y_n = z[31] ? y - (x >>> i) : y + (x >>> i);
        z_n = z[31] ? z + ATAN[i] : z - ATAN[i];
    end
`ifdef CORDIC_RANGE_CHECK_EN
    logic err_q;
    assign oor = angle_in > AMAX || angle_in < -AMAX;
    assign err = err_q;
    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else if (in_ready && in_valid) err_q <= oor;
    end
`else
    assign oor = 1'b0;
    assign err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            i <= '0;
            x <= '0;
            y <= '0;
            z <= '0;
            cos_out <= '0;
            sin_out <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state <= oor ? HOLD : ROTATE;
                    x <= K;
                    y <= '0;
                    z <= angle_in;
                    i <= '0;
                    if (oor) begin
                        cos_out <= '0;
                        sin_out <= '0;
                    end
                end
                ROTATE: begin
                    x <= x_n;
                    y <= y_n;
                    z <= z_n;
                    i <= i + 5'd1;
                    if (i == 5'(ITER - 1)) begin
                        state <= HOLD;
                        cos_out <= x_n;
                        sin_out <= y_n;
                    end
                end
                HOLD: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_sincos.sv
// tb_cordic_sincos: random and directed angles checked against real-valued trig reference
module tb_cordic_sincos;
    localparam int ITER = 16;
    localparam longint TOL = 4 * (64'sd1 << (30 - ITER));
    localparam longint AMAX = 1686629713;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [31:0] angle_in = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic signed [31:0] cos_out, sin_out;
    logic err;
    int errors = 0;
    int checks = 0;

    cordic_sincos #(.ITER(ITER)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .angle_in(angle_in), .out_valid(out_valid), .out_ready(out_ready),
        .cos_out(cos_out), .sin_out(sin_out), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp, input longint tol = 0);
        checks++;
        if (got - exp > tol || exp - got > tol) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_cos"}, cos_out, 0);
        check({tag, "_sin"}, sin_out, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic run(input logic signed [31:0] a, input int bp);
        longint ec, es, tol, eerr;
        int lat, exp_lat;
        logic signed [31:0] hc, hs;
        real r;
        bit bad;
        r = real'(a) / 2.0**30;
        ec = longint'($cos(r) * 2.0**30);
        es = longint'($sin(r) * 2.0**30);
        tol = TOL;
        exp_lat = ITER;
        eerr = 0;
        bad = longint'(a) > AMAX || longint'(a) < -AMAX;
`ifdef CORDIC_RANGE_CHECK_EN
        if (bad) begin
            ec = 0; es = 0; tol = 0; exp_lat = 1; eerr = 1;
        end
`else
        if (bad) $display("note: angle %0d outside legal range skipped", a);
`endif
        out_ready = (bp == 0);
        check("idle_in_ready", in_ready, 1);
        in_valid = 1'b1;
        angle_in = a;
        @(negedge clk);
        in_valid = 1'b0;
        angle_in = 32'($urandom);
        check("busy_in_ready", in_ready, exp_lat == 1 ? 0 : 0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (exp_lat == 1 && lat == 0) lat = 1;
        check("latency", lat, exp_lat);
        if (!bad || eerr == 1) begin
            check("cos", cos_out, ec, tol);
            check("sin", sin_out, es, tol);
        end
        check("err", err, eerr);
        check("hold_valid", out_valid, 1);
        hc = cos_out;
        hs = sin_out;
        if (bp > 0) begin
            in_valid = 1'b1;
            repeat (bp) begin
                @(negedge clk);
                check("bp_valid", out_valid, 1);
                check("bp_in_ready", in_ready, 0);
                check("bp_cos_stable", cos_out, hc);
                check("bp_sin_stable", sin_out, hs);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("drop_valid", out_valid, 0);
        check("back_in_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        int hi;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_idle_zero("reset");
        run(32'sd0, 0);
        run(32'sd843314857, 0);
        check("pi4_equal", cos_out, sin_out, 2 * TOL);
        run(-32'sd562209905, 2);
        run(32'sd1686629713, 0);
        run(-32'sd1686629713, 5);
`ifdef CORDIC_RANGE_CHECK_EN
        run(32'sd1800000000, 0);
        run(-32'sd1800000000, 3);
        run(32'sd100000000, 0);
`endif
        in_valid = 1'b1;
        angle_in = 32'sd400000000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_busy", in_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        check_idle_zero("mid_reset");
        reset = 1'b0;
        hi = 0;
        repeat (ITER + 3) begin
            @(negedge clk);
            if (out_valid) hi++;
        end
        check("no_ghost_valid", hi, 0);
        run(32'sd400000000, 0);
        for (int k = 0; k < 24; k++)
            run(32'(longint'($urandom_range(32'd3373259426, 0)) - AMAX), (k % 3 == 0) ? 2 : 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
